// File: rtl/tick_period_meter_pkg.sv
// Shared definitions for the tick period meter: FSM state encoding and default widths.
package tick_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEASURE   = 2'd1,
    ST_TIMED_OUT = 2'd2
  } tm_state_t;

  localparam int DEFAULT_N           = 17;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/tick_period_meter_sync.sv
// Synchroniser chain for an asynchronous tick plus a single-cycle rising-edge detector.
module sync_rise_detect
  import tick_period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   sync_out;

  assign sync_out = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], tick_in};
      prev_reg <= sync_out;
    end
  end

  // prev starts at 0, so a tick already high when reset releases yields one rise.
  assign rise = sync_out & ~prev_reg;

endmodule

// File: rtl/tick_period_meter.sv
// Measures clock cycles between rising edges of an asynchronous tick and flags missing ticks.
// Optional period_min/period_max tracking is built when PERIOD_MINMAX_EN is defined.
module tick_period_meter
  import tick_period_meter_pkg::*;
#(
  parameter int N           = DEFAULT_N,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = (2 ** N) - 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick_in,
  input  logic         clear,
  output logic [N-1:0] period,
  output logic         period_valid,
  output logic         timeout
`ifdef PERIOD_MINMAX_EN
  ,
  output logic [N-1:0] period_min,
  output logic [N-1:0] period_max
`endif
);

  localparam logic [N-1:0] TIMEOUT_CNT = N'(TIMEOUT);
  localparam logic [N-1:0] ONE         = N'(1);

  tm_state_t    state_reg, state_next;
  logic [N-1:0] cnt_reg, cnt_next;
  logic [N-1:0] period_reg, period_next;
  logic         valid_reg, valid_next;
  logic         timeout_reg, timeout_next;
  logic         rise;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .tick_in(tick_in),
    .rise   (rise)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      period_reg  <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      period_reg  <= period_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  // A rise coinciding with cnt==TIMEOUT keeps the FSM measuring.
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:      if (rise) state_next = ST_MEASURE;
        ST_MEASURE:   if (!rise && cnt_reg == TIMEOUT_CNT) state_next = ST_TIMED_OUT;
        ST_TIMED_OUT: if (rise) state_next = ST_MEASURE;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // Counter stops at TIMEOUT on leaving MEASURE, so it can never wrap.
  always_comb begin
    cnt_next     = cnt_reg;
    period_next  = period_reg;
    valid_next   = 1'b0;
    timeout_next = timeout_reg;
    if (clear) begin
      cnt_next     = '0;
      period_next  = '0;
      timeout_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_next = rise ? ONE : '0;
        end
        ST_MEASURE: begin
          if (rise) begin
            period_next = cnt_reg;
            valid_next  = 1'b1;
            cnt_next    = ONE;
          end else if (cnt_reg == TIMEOUT_CNT) begin
            timeout_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + ONE;
          end
        end
        ST_TIMED_OUT: begin
          if (rise) cnt_next = ONE;
        end
        default: begin
          cnt_next = '0;
        end
      endcase
    end
  end

  assign period       = period_reg;
  assign period_valid = valid_reg;
  assign timeout      = timeout_reg;

`ifdef PERIOD_MINMAX_EN
  logic [N-1:0] min_reg, min_next;
  logic [N-1:0] max_reg, max_next;

  always_comb begin
    min_next = min_reg;
    max_next = max_reg;
    if (clear) begin
      min_next = {N{1'b1}};
      max_next = '0;
    end else if (valid_next) begin
      if (period_next < min_reg) min_next = period_next;
      if (period_next > max_reg) max_next = period_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      min_reg <= {N{1'b1}};
      max_reg <= '0;
    end else begin
      min_reg <= min_next;
      max_reg <= max_next;
    end
  end

  assign period_min = min_reg;
  assign period_max = max_reg;
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter (N=8, TIMEOUT=200, SYNC_STAGES=2).
module tb_tick_period_meter;

  localparam int N  = 8;
  localparam int TO = 200;

  logic         clock   = 1'b0;
  logic         reset   = 1'b0;
  logic         tick_in = 1'b0;
  logic         clear   = 1'b0;
  logic [N-1:0] period;
  logic         period_valid;
  logic         timeout;
`ifdef PERIOD_MINMAX_EN
  logic [N-1:0] period_min;
  logic [N-1:0] period_max;
`endif

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   vcount = 0;
  int   dbl    = 0;
  logic vprev  = 1'b0;
  int   v0;

  typedef struct {
    int         gap;
    int         exp_pulses;
    logic [7:0] exp_period;
    logic       exp_timeout;
  } vec_t;

  vec_t vecs[6];

  always #5 clock = ~clock;

  tick_period_meter #(
    .N(N),
    .SYNC_STAGES(2),
    .TIMEOUT(TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick_in     (tick_in),
    .clear       (clear),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout)
`ifdef PERIOD_MINMAX_EN
    ,
    .period_min  (period_min),
    .period_max  (period_max)
`endif
  );

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (period_valid === 1'b1) begin
      vcount = vcount + 1;
      if (vprev === 1'b1) dbl = dbl + 1;
    end
    vprev = period_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic edge_pulse();
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    vecs[0] = '{gap: 37,  exp_pulses: 1, exp_period: 8'd37,  exp_timeout: 1'b0};
    vecs[1] = '{gap: 2,   exp_pulses: 1, exp_period: 8'd2,   exp_timeout: 1'b0};
    vecs[2] = '{gap: 3,   exp_pulses: 1, exp_period: 8'd3,   exp_timeout: 1'b0};
    vecs[3] = '{gap: 200, exp_pulses: 1, exp_period: 8'd200, exp_timeout: 1'b0};
    vecs[4] = '{gap: 201, exp_pulses: 0, exp_period: 8'd0,   exp_timeout: 1'b1};
    vecs[5] = '{gap: 99,  exp_pulses: 1, exp_period: 8'd99,  exp_timeout: 1'b0};

    // Reset state
    cyc(3);
    chk("reset_period", period, 0);
    chk("reset_valid", period_valid, 0);
    chk("reset_timeout", timeout, 0);
    $display("reset: period=%0d valid=%0b timeout=%0b", period, period_valid, timeout);
    reset = 1'b1;
    cyc(2);

    // Table: two edges `gap` apart from a cleared state
    for (int i = 0; i < 6; i++) begin
      do_clear();
      v0 = vcount;
      edge_pulse();
      cyc(vecs[i].gap - 1);
      edge_pulse();
      cyc(4);
      chk("vec_pulses", vcount - v0, vecs[i].exp_pulses);
      chk("vec_period", period, vecs[i].exp_period);
      chk("vec_timeout", timeout, vecs[i].exp_timeout);
      $display("vec %0d: gap=%0d pulses=%0d period=%0d timeout=%0b",
               i, vecs[i].gap, vcount - v0, period, timeout);
    end

    // Test 1: async reset mid-measure, then first edge silent, second 50 later
    do_clear();
    edge_pulse();
    cyc(19);
    edge_pulse();
    cyc(4);
    chk("t1_pre_period", period, 20);
    edge_pulse();
    cyc(10);
    reset = 1'b0;
    #1;
    chk("t1_async_period", period, 0);
    chk("t1_async_valid", period_valid, 0);
    chk("t1_async_timeout", timeout, 0);
    cyc(2);
    reset = 1'b1;
    v0 = vcount;
    edge_pulse();
    cyc(49);
    edge_pulse();
    cyc(4);
    chk("t1_pulses", vcount - v0, 1);
    chk("t1_period", period, 50);
    $display("t1 reset: pulses=%0d period=%0d", vcount - v0, period);

    // Tick held high through reset release counts as an edge
    reset = 1'b0;
    tick_in = 1'b1;
    cyc(2);
    v0 = vcount;
    reset = 1'b1;
    cyc(3);
    tick_in = 1'b0;
    cyc(22);
    edge_pulse();
    cyc(4);
    chk("t1b_pulses", vcount - v0, 1);
    chk("t1b_period", period, 25);
    $display("t1b high-through-reset: pulses=%0d period=%0d", vcount - v0, period);

    // Test 2: steady ticks every 37 clocks, latency 3 clocks
    do_clear();
    v0 = vcount;
    for (int e = 0; e < 5; e++) begin
      tick_in = 1'b1;
      cyc(1);
      tick_in = 1'b0;
      cyc(1);
      chk("t2_early_valid", period_valid, 0);
      cyc(1);
      if (e == 0) begin
        chk("t2_first_valid", period_valid, 0);
      end else begin
        chk("t2_valid", period_valid, 1);
        chk("t2_period", period, 37);
      end
      cyc(34);
    end
    chk("t2_pulses", vcount - v0, 4);
    $display("t2 steady: pulses=%0d period=%0d", vcount - v0, period);

    // Test 3: timeout after 200 idle clocks, recovery, clear
    do_clear();
    edge_pulse();
    cyc(39);
    edge_pulse();
    cyc(2);
    chk("t3_valid", period_valid, 1);
    chk("t3_period", period, 40);
    cyc(199);
    chk("t3_timeout_before", timeout, 0);
    cyc(1);
    chk("t3_timeout_at", timeout, 1);
    chk("t3_period_hold", period, 40);
    v0 = vcount;
    edge_pulse();
    cyc(19);
    edge_pulse();
    cyc(4);
    chk("t3_rec_pulses", vcount - v0, 1);
    chk("t3_rec_period", period, 20);
    chk("t3_rec_timeout", timeout, 1);
    do_clear();
    chk("t3_clr_timeout", timeout, 0);
    chk("t3_clr_period", period, 0);
    $display("t3 timeout: period=%0d timeout=%0b", period, timeout);

    // Test 5: clear coincident with a detected rise
    do_clear();
    edge_pulse();
    cyc(14);
    edge_pulse();
    cyc(4);
    chk("t5_pre_period", period, 15);
    v0 = vcount;
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
    cyc(1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t5_clr_valid", period_valid, 0);
    chk("t5_clr_period", period, 0);
    cyc(2);
    chk("t5_clr_pulses", vcount - v0, 0);
    v0 = vcount;
    edge_pulse();
    cyc(9);
    edge_pulse();
    cyc(4);
    chk("t5_pulses", vcount - v0, 1);
    chk("t5_period", period, 10);
    $display("t5 clear+rise: pulses=%0d period=%0d", vcount - v0, period);

`ifdef PERIOD_MINMAX_EN
    // Test 6: min/max tracking
    do_clear();
    chk("t6_init_min", period_min, 8'hFF);
    chk("t6_init_max", period_max, 0);
    edge_pulse();
    cyc(29);
    edge_pulse();
    cyc(11);
    edge_pulse();
    cyc(44);
    edge_pulse();
    cyc(4);
    chk("t6_min", period_min, 12);
    chk("t6_max", period_max, 45);
    chk("t6_period", period, 45);
    do_clear();
    chk("t6_clr_min", period_min, 8'hFF);
    chk("t6_clr_max", period_max, 0);
    $display("t6 minmax: min=%0d max=%0d", period_min, period_max);
`endif

    chk("no_double_pulse", dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
